// File: rtl/if_id_pipe_reg_pkg.sv
// Shared pipeline types for the RV32I core: datapath width, the canonical NOP,
// IF/ID control states and the per-stage payload struct.
package riscv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } ifid_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch/hazard-side bundle into the IF/ID register and its decode-side results.
// master = fetch + hazard unit + decode consumer, slave = the IF/ID register.
interface if_id_pipe_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  if_pc;
    logic [XLEN-1:0]  if_instr;
    logic             if_valid;
    logic             IF_ID_Write;
    logic             flush;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_instr;
    logic             id_valid;
    logic             stalled;
    logic             stall_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output if_pc, if_instr, if_valid, IF_ID_Write, flush,
        input  id_pc, id_instr, id_valid, stalled, stall_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_pc, if_instr, if_valid, IF_ID_Write, flush,
        output id_pc, id_instr, id_valid, stalled, stall_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at MAX instead of wrapping.
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall hold, flush-to-bubble and stall watchdog.
// Define IF_ID_PERF_CNT_EN to build the saturating stall/flush performance counters.
module if_id_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN          = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR     = riscv_pipe_pkg::NOP_INSTR,
    parameter int              STALL_TIMEOUT = 8,
    parameter int              CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    if_id_pipe_reg_if.slave     bus
);

    localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

    ifid_state_t       r_state;
    ifid_state_t       w_next;
    logic [XLEN-1:0]   r_id_pc;
    logic [XLEN-1:0]   r_id_instr;
    logic              r_id_valid;
    logic              r_stall_err;
    logic              w_stall_cond;
    logic              w_run_inc;
    logic              w_run_hit;
    logic [RUN_W-1:0]  w_run_cnt;

    assign w_stall_cond = !bus.IF_ID_Write && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HOLD: begin
                if (bus.flush)            w_next = SQUASH;
                else if (bus.IF_ID_Write) w_next = RUN;
                else                      w_next = HOLD;
            end
            default: begin
                if (bus.flush)             w_next = SQUASH;
                else if (!bus.IF_ID_Write) w_next = HOLD;
                else                       w_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_pc    <= '0;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (bus.flush) begin
            r_id_pc    <= bus.if_pc;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (bus.IF_ID_Write) begin
            r_id_pc    <= bus.if_pc;
            r_id_instr <= bus.if_valid ? bus.if_instr : NOP_INSTR;
            r_id_valid <= bus.if_valid;
        end
    end

    // Run length counts every edge that lands in HOLD; anything else ends the run.
    assign w_run_inc = (w_next == HOLD);
    assign w_run_hit = w_run_inc && (w_run_cnt >= RUN_W'(STALL_TIMEOUT - 1));

    sat_counter #(
        .WIDTH (RUN_W),
        .MAX   (RUN_W'(STALL_TIMEOUT))
    ) u_run_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_run_inc),
        .i_clear (!w_run_inc),
        .o_count (w_run_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_err <= 1'b0;
        end else if (w_run_hit) begin
            r_stall_err <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall_cond),
        .i_clear (1'b0),
        .o_count (bus.stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (bus.flush),
        .i_clear (1'b0),
        .o_count (bus.flush_cnt)
    );
`else
    assign bus.stall_cnt = {CNT_W{w_stall_cond & 1'b0}};
    assign bus.flush_cnt = '0;
`endif

    assign bus.id_pc     = r_id_pc;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_valid  = r_id_valid;
    assign bus.stalled   = (r_state == HOLD);
    assign bus.stall_err = r_stall_err;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: vector table for single-edge behaviour plus
// hand-written sequences for the stall watchdog and reset-mid-stall cases.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;

    if_id_pipe_reg_if #(.XLEN(32), .CNT_W(16)) bus ();

    if_id_pipe_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        wr;
        logic        fl;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic        expValid;
        logic        expStalled;
        logic        expErr;
        int          expStallCnt;
        int          expFlushCnt;
    } vec_t;

    vec_t vecs[9];
    int   nVec;
    int   nMis;

    task automatic applyStimulus(input logic rst, input logic wr, input logic fl,
                                 input logic vld, input logic [31:0] pc,
                                 input logic [31:0] instr);
        rst_n           = rst;
        bus.IF_ID_Write = wr;
        bus.flush       = fl;
        bus.if_valid    = vld;
        bus.if_pc       = pc;
        bus.if_instr    = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ePc,
                               input logic [31:0] eInstr, input logic eValid,
                               input logic eStalled, input logic eErr,
                               input int eStallCnt, input int eFlushCnt);
        int sc;
        int fc;
`ifdef IF_ID_PERF_CNT_EN
        sc = eStallCnt;
        fc = eFlushCnt;
`else
        sc = 0 * eStallCnt;
        fc = 0 * eFlushCnt;
`endif
        nVec++;
        if (bus.id_pc !== ePc || bus.id_instr !== eInstr || bus.id_valid !== eValid ||
            bus.stalled !== eStalled || bus.stall_err !== eErr ||
            bus.stall_cnt !== 16'(sc) || bus.flush_cnt !== 16'(fc)) begin
            nMis++;
            $display("[TB] FAIL %s: got pc=%h instr=%h v=%b st=%b err=%b sc=%0d fc=%0d, want pc=%h instr=%h v=%b st=%b err=%b sc=%0d fc=%0d",
                     name, bus.id_pc, bus.id_instr, bus.id_valid, bus.stalled, bus.stall_err,
                     bus.stall_cnt, bus.flush_cnt, ePc, eInstr, eValid, eStalled, eErr, sc, fc);
        end
    endtask

    initial begin
        nVec = 0;
        nMis = 0;

        //            name          rst  wr   fl   vld  pc            instr          expPc         expInstr       v    st   err  sc fc
        vecs[0] = '{"reset0",      1'b0,1'b1,1'b0,1'b1,32'h0000_0040,32'hDEAD_BEEF,32'h0000_0000,NOP,          1'b0,1'b0,1'b0,0, 0};
        vecs[1] = '{"reset1",      1'b0,1'b1,1'b0,1'b1,32'h0000_0040,32'hDEAD_BEEF,32'h0000_0000,NOP,          1'b0,1'b0,1'b0,0, 0};
        vecs[2] = '{"load",        1'b1,1'b1,1'b0,1'b1,32'h0000_0100,32'h0050_0093,32'h0000_0100,32'h0050_0093,1'b1,1'b0,1'b0,0, 0};
        vecs[3] = '{"stall1",      1'b1,1'b0,1'b0,1'b1,32'h0000_0104,32'h00A0_0113,32'h0000_0100,32'h0050_0093,1'b1,1'b1,1'b0,1, 0};
        vecs[4] = '{"resume",      1'b1,1'b1,1'b0,1'b1,32'h0000_0104,32'h00A0_0113,32'h0000_0104,32'h00A0_0113,1'b1,1'b0,1'b0,1, 0};
        vecs[5] = '{"flushStall",  1'b1,1'b0,1'b1,1'b1,32'h0000_0108,32'h0000_0067,32'h0000_0108,NOP,          1'b0,1'b0,1'b0,1, 1};
        vecs[6] = '{"flushAgain",  1'b1,1'b1,1'b1,1'b1,32'h0000_0200,32'h1234_5678,32'h0000_0200,NOP,          1'b0,1'b0,1'b0,1, 2};
        vecs[7] = '{"invalidLoad", 1'b1,1'b1,1'b0,1'b0,32'h0000_0204,32'hFFFF_FFFF,32'h0000_0204,NOP,          1'b0,1'b0,1'b0,1, 2};
        vecs[8] = '{"load2",       1'b1,1'b1,1'b0,1'b1,32'h0000_0208,32'h0000_0033,32'h0000_0208,32'h0000_0033,1'b1,1'b0,1'b0,1, 2};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].fl, vecs[i].vld, vecs[i].pc, vecs[i].instr);
            checkOutput(vecs[i].name, vecs[i].expPc, vecs[i].expInstr, vecs[i].expValid,
                        vecs[i].expStalled, vecs[i].expErr, vecs[i].expStallCnt, vecs[i].expFlushCnt);
        end

        // Watchdog: eight consecutive stall edges, err must not set on the seventh.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_020C + 32'(k), 32'h0000_0013);
            if (k == 7)
                checkOutput("timeout7", 32'h0000_0208, 32'h0000_0033, 1'b1, 1'b1, 1'b0, 8, 2);
            if (k == 8)
                checkOutput("timeout8", 32'h0000_0208, 32'h0000_0033, 1'b1, 1'b1, 1'b1, 9, 2);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0010_0093);
        checkOutput("errSticky", 32'h0000_0300, 32'h0010_0093, 1'b1, 1'b0, 1'b1, 9, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'h0020_0093);
        checkOutput("errCleared", 32'h0000_0000, NOP, 1'b0, 1'b0, 1'b0, 0, 0);

        // Reset in the middle of a stall run must discard the run length too.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0030_0093);
        checkOutput("loadPreStall", 32'h0000_0400, 32'h0030_0093, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'h0040_0093);
        checkOutput("hold3", 32'h0000_0400, 32'h0030_0093, 1'b1, 1'b1, 1'b0, 3, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'h0040_0093);
        checkOutput("resetMidStall", 32'h0000_0000, NOP, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0408, 32'h0050_0093);
            if (k == 7)
                checkOutput("freshRun7", 32'h0000_0000, NOP, 1'b0, 1'b1, 1'b0, 7, 0);
            if (k == 8)
                checkOutput("freshRun8", 32'h0000_0000, NOP, 1'b0, 1'b1, 1'b1, 8, 0);
        end

        // Flush out of HOLD clears the run length: seven more stalls stay clean.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0060_0093);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0504, 32'h0070_0093);
        checkOutput("flushFromHold", 32'h0000_0504, NOP, 1'b0, 1'b0, 1'b0, 4, 1);
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0508, 32'h0080_0093);
        checkOutput("postFlushRun7", 32'h0000_0504, NOP, 1'b0, 1'b1, 1'b0, 11, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
